// File: rtl/icache_data_ctrl_pkg.sv
// Shared constants, FSM encoding and beat-geometry helpers
// for the I-cache data array controller.
package icache_data_ctrl_pkg;

  localparam int SRAM_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Beats per 128-bit bank word.
  function automatic int bpb_of(input int beat_w);
    return SRAM_W / beat_w;
  endfunction

  // Beats per full line.
  function automatic int nbeat_of(input int banks, input int beat_w);
    return banks * bpb_of(beat_w);
  endfunction

endpackage

// File: rtl/icache_data_ctrl_if.sv
// Read and refill handshake bundle between the cache FSM/IFU and the
// data controller; master = cache side, slave = data controller.
interface icache_data_ctrl_if #(
  parameter int IDX_LEN = 7,
  parameter int BLK_LEN = 6,
  parameter int WAY_NUM = 2,
  parameter int BEAT_W  = 64
);
  import icache_data_ctrl_pkg::*;

  logic               rd_req_i;
  logic               rd_ready_o;
  logic [IDX_LEN-1:0] rd_index_i;
  logic [BLK_LEN-1:0] rd_blk_i;
  logic [WAY_NUM-1:0] rd_way_i;
  logic               rd_valid_o;
  logic [SRAM_W-1:0]  rd_data_o;

  logic               refill_start_i;
  logic [IDX_LEN-1:0] refill_index_i;
  logic [WAY_NUM-1:0] refill_way_i;
  logic               refill_valid_i;
  logic               refill_ready_o;
  logic [BEAT_W-1:0]  refill_data_i;
  logic               refill_last_i;
  logic               refill_done_o;
  logic               refill_err_o;

  modport master (
    output rd_req_i, rd_index_i, rd_blk_i, rd_way_i,
    output refill_start_i, refill_index_i, refill_way_i,
    output refill_valid_i, refill_data_i, refill_last_i,
    input  rd_ready_o, rd_valid_o, rd_data_o,
    input  refill_ready_o, refill_done_o, refill_err_o
  );

  modport slave (
    input  rd_req_i, rd_index_i, rd_blk_i, rd_way_i,
    input  refill_start_i, refill_index_i, refill_way_i,
    input  refill_valid_i, refill_data_i, refill_last_i,
    output rd_ready_o, rd_valid_o, rd_data_o,
    output refill_ready_o, refill_done_o, refill_err_o
  );

endinterface

// File: rtl/icache_refill_buf.sv
// Refill beat collector: packs beats into bank words, raises a one-cycle
// write request per completed word, flags short/overlong bursts.
module icache_refill_buf
  import icache_data_ctrl_pkg::*;
#(
  parameter int BANK_NUM = 4,
  parameter int BEAT_W   = 64,
  parameter int BKW      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc,
  input  logic [BEAT_W-1:0] data,
  input  logic              last,
  output logic              fin,
  output logic              wr_pend,
  output logic [BKW-1:0]    wr_bank,
  output logic [SRAM_W-1:0] wr_data,
  output logic              err
);

  localparam int BPB   = bpb_of(BEAT_W);
  localparam int NBEAT = nbeat_of(BANK_NUM, BEAT_W);
  localparam int CW    = $clog2(NBEAT) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(NBEAT - 1);
  localparam logic [31:0]   SUB_END = 32'(BPB - 1);

  logic [CW-1:0]     cnt;
  logic [SRAM_W-1:0] bank_buf;
  logic [SRAM_W-1:0] word;
  logic [31:0]       sub;
  logic              at_end;
  logic              full;

  assign sub    = 32'(cnt) % BPB;
  assign at_end = cnt == CNT_END;
  assign full   = sub == SUB_END;
  // The beat budget running out ends the burst just like last does.
  assign fin    = acc & (last | at_end);

  always_comb begin
    word = bank_buf;
    word[sub*BEAT_W +: BEAT_W] = data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      bank_buf <= '0;
      wr_pend  <= 1'b0;
      wr_bank  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
    end else begin
      wr_pend <= acc & full;
      if (clr) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (acc) begin
        cnt      <= cnt + 1'b1;
        bank_buf <= word;
        if (full) begin
          wr_data <= word;
          wr_bank <= BKW'(32'(cnt) / BPB);
        end
        if (fin) err <= last ^ at_end;
      end
    end
  end

endmodule

// File: rtl/icache_data_ctrl.sv
// I-cache data array controller: late-way-select read pipeline, refill
// FSM and per-macro SRAM port muxing for WAY_NUM x BANK_NUM banks.
module icache_data_ctrl
  import icache_data_ctrl_pkg::*;
#(
  parameter int IDX_LEN  = 7,
  parameter int BLK_LEN  = 6,
  parameter int BANK_NUM = 4,
  parameter int WAY_NUM  = 2,
  parameter int BEAT_W   = 64
) (
  input  logic clk,
  input  logic rst,
  icache_data_ctrl_if.slave bus,
  output logic [WAY_NUM*BANK_NUM*IDX_LEN-1:0] sram_addr_o,
  output logic [WAY_NUM*BANK_NUM-1:0]         sram_cen_o,
  output logic [WAY_NUM*BANK_NUM-1:0]         sram_wen_o,
  output logic [WAY_NUM*BANK_NUM*SRAM_W-1:0]  sram_wmask_o,
  output logic [WAY_NUM*BANK_NUM*SRAM_W-1:0]  sram_wdata_o,
  input  logic [WAY_NUM*BANK_NUM*SRAM_W-1:0]  sram_rdata_i
);

  localparam int NM  = WAY_NUM * BANK_NUM;
  localparam int BKW = BLK_LEN - 4;

  state_e             state_q, state_d;
  logic [IDX_LEN-1:0] fill_idx_q;
  logic [WAY_NUM-1:0] fill_way_q;
  logic               rd_pend_q;
  logic [BKW-1:0]     rd_bank_q;
  logic [BKW-1:0]     rd_bank;
  logic               rd_acc;
  logic               start;
  logic               acc;
  logic               fin;
  logic               wr_pend;
  logic               err;
  logic [BKW-1:0]     wr_bank;
  logic [SRAM_W-1:0]  wr_data;
  logic [SRAM_W-1:0]  rd_data;
  logic               unused_blk;

  assign unused_blk = ^bus.rd_blk_i[3:0];

  assign bus.rd_ready_o     = state_q == IDLE;
  assign bus.refill_ready_o = state_q == FILL;
  assign bus.refill_done_o  = state_q == FLUSH;
  assign bus.refill_err_o   = (state_q == FLUSH) & err;
  assign bus.rd_valid_o     = rd_pend_q;
  assign bus.rd_data_o      = rd_data;

  assign rd_bank = bus.rd_blk_i[BLK_LEN-1:4];
  // Gate with rst so no macro is enabled while reset is held.
  assign rd_acc  = rst & bus.rd_req_i & bus.rd_ready_o;
  assign start   = bus.refill_start_i & (state_q == IDLE);
  assign acc     = bus.refill_valid_i & bus.refill_ready_o;

  icache_refill_buf #(
    .BANK_NUM (BANK_NUM),
    .BEAT_W   (BEAT_W),
    .BKW      (BKW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .acc     (acc),
    .data    (bus.refill_data_i),
    .last    (bus.refill_last_i),
    .fin     (fin),
    .wr_pend (wr_pend),
    .wr_bank (wr_bank),
    .wr_data (wr_data),
    .err     (err)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (fin) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fill_idx_q <= '0;
      fill_way_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_acc;
      if (rd_acc) rd_bank_q <= rd_bank;
      if (start) begin
        fill_idx_q <= bus.refill_index_i;
        fill_way_q <= bus.refill_way_i;
      end
    end
  end

  // Late way select: hit vector arrives with the SRAM data.
  // Multi-hot ORs the ways together, all-zero yields zero.
  always_comb begin
    rd_data = '0;
    if (rd_pend_q) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (bus.rd_way_i[w])
          rd_data = rd_data |
            sram_rdata_i[(w*BANK_NUM + int'(rd_bank_q))*SRAM_W +: SRAM_W];
      end
    end
  end

  for (genvar m = 0; m < NM; m++) begin : g_mac
    localparam int W = m / BANK_NUM;
    localparam int B = m % BANK_NUM;
    logic wsel;
    logic rsel;
    assign wsel = wr_pend & fill_way_q[W] & (wr_bank == BKW'(B));
    assign rsel = rd_acc & (rd_bank == BKW'(B));
    assign sram_cen_o[m] = ~(wsel | rsel);
    assign sram_wen_o[m] = ~wsel;
    assign sram_wmask_o[m*SRAM_W +: SRAM_W] = {SRAM_W{~wsel}};
    assign sram_wdata_o[m*SRAM_W +: SRAM_W] = wr_data;
    assign sram_addr_o[m*IDX_LEN +: IDX_LEN] =
      bus.rd_ready_o ? bus.rd_index_i : fill_idx_q;
  end

endmodule
